// File: rtl/train_axle_emulator_pkg.sv
// Shared definitions for the axle emulator: FSM states, direction meaning and sensor codes.
// The level-crossing controller imports the same package so both sides agree on direction.
package train_axle_emulator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZERO,
        ST_LEAD,
        ST_BOTH,
        ST_TRAIL,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic DIR_A2B = 1'b0;
    localparam logic DIR_B2A = 1'b1;

    // {a,b} sensor codes
    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_A    = 2'b10;
    localparam logic [1:0] AB_BOTH = 2'b11;
    localparam logic [1:0] AB_B    = 2'b01;

    // Lead sensor is the one the wheel reaches first in the selected direction.
    function automatic logic [1:0] sensor_code(input state_t s, input logic d);
        logic [1:0] code;
        code = AB_NONE;
        case (s)
            ST_LEAD:  code = (d == DIR_B2A) ? AB_B : AB_A;
            ST_BOTH:  code = AB_BOTH;
            ST_TRAIL: code = (d == DIR_A2B) ? AB_B : AB_A;
            default:  code = AB_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/train_axle_emulator_phase_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
// Loading N-1 on state entry makes the state last exactly N cycles.
module lc_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/train_axle_emulator.sv
// Two-sensor axle waveform generator for one track: emits 'axles' Gray-coded
// 00/lead/11/trail cycles in the chosen direction, then a quiet gap and a done pulse.
module train_axle_emulator
    import train_axle_emulator_pkg::*;
#(
    parameter int PHASE_CYC = 1,
    parameter int GAP_CYC   = 4,
    parameter int AXLE_W    = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              dir,
    input  logic [AXLE_W-1:0] axles,
    input  logic              abort,
    output logic              a,
    output logic              b,
    output logic              busy,
    output logic              done,
    output logic [AXLE_W-1:0] axle_cnt
);

    localparam int MAX_CYC = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [AXLE_W-1:0] axles_q, axles_d;
    logic [AXLE_W-1:0] cnt_q, cnt_d;
    logic [1:0]        ab_q, ab_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_value;
    logic              tmr_expire;

    lc_phase_timer #(
        .W (TMR_W)
    ) u_phase_timer (
        .clk        (Clk),
        .srst       (Reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .expire     (tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        axles_d = axles_q;
        cnt_d   = cnt_q;
        if (abort) begin
            // Also covers abort+start in IDLE: the start is dropped.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dir_d   = dir;
                        axles_d = axles;
                        cnt_d   = '0;
                        state_d = (axles == '0) ? ST_DONE : ST_ZERO;
                    end
                end
                ST_ZERO:  if (tmr_expire) state_d = ST_LEAD;
                ST_LEAD:  if (tmr_expire) state_d = ST_BOTH;
                ST_BOTH:  if (tmr_expire) state_d = ST_TRAIL;
                ST_TRAIL: begin
                    if (tmr_expire) begin
                        cnt_d   = cnt_q + AXLE_W'(1);
                        state_d = (cnt_d < axles_q) ? ST_ZERO : ST_GAP;
                    end
                end
                ST_GAP:   if (tmr_expire) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        ab_d      = sensor_code(state_d, dir_d);
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);
        tmr_load  = (state_d != state_q);
        tmr_value = (state_d == ST_GAP) ? TMR_W'(GAP_CYC - 1) : TMR_W'(PHASE_CYC - 1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_A2B;
            axles_q <= '0;
            cnt_q   <= '0;
            ab_q    <= AB_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            axles_q <= axles_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a        = ab_q[1];
    assign b        = ab_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign axle_cnt = cnt_q;

endmodule

// File: tb/tb_train_axle_emulator.sv
// Bench: two emulators (PHASE_CYC=1 and 2) share stimulus; each has a cycle-timeline model.
module tb_train_axle_emulator;

    localparam int AW  = 5;
    localparam int GAP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dir;
    logic [AW-1:0] axles;
    logic          abort;

    logic          a_o    [2];
    logic          b_o    [2];
    logic          busy_o [2];
    logic          done_o [2];
    logic [AW-1:0] cnt_o  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    function automatic int outs(input int i);
        return int'({a_o[i], b_o[i], busy_o[i], done_o[i], cnt_o[i]});
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int P = gi + 1;

        train_axle_emulator #(
            .PHASE_CYC (P),
            .GAP_CYC   (GAP),
            .AXLE_W    (AW)
        ) u_dut (
            .Clk      (clk),
            .Reset    (rst),
            .start    (start),
            .dir      (dir),
            .axles    (axles),
            .abort    (abort),
            .a        (a_o[gi]),
            .b        (b_o[gi]),
            .busy     (busy_o[gi]),
            .done     (done_o[gi]),
            .axle_cnt (cnt_o[gi])
        );

        // Model: a train is a timeline t = cycles since the accept edge, t = 0..T.
        bit active   = 0;
        bit m_dir    = 0;
        bit forced   = 1;
        int t        = 0;
        int n        = 0;
        int tt       = 0;
        int cnt_hold = 0;
        int cyc      = 0;
        int acc_cyc  = 0;
        int last_lat = 0;
        int accepted = 0;
        int killed   = 0;
        int dones    = 0;
        logic [1:0] prev_ab = 2'b00;

        function automatic int cur_cnt();
            return (t < 4 * P * n) ? t / (4 * P) : n;
        endfunction

        always @(posedge clk) begin
            cyc++;
            forced = 0;
            if (rst) begin
                if (active && t < tt) killed++;
                active   = 0;
                cnt_hold = 0;
                forced   = 1;
            end else if (active) begin
                if (abort) begin
                    if (t < tt) killed++;
                    cnt_hold = cur_cnt();
                    active   = 0;
                    forced   = 1;
                end else if (t == tt) begin
                    cnt_hold = n;
                    active   = 0;
                end else begin
                    t++;
                end
            end else if (start && !abort) begin
                active  = 1;
                t       = 0;
                n       = int'(axles);
                m_dir   = dir;
                tt      = (n == 0) ? 0 : 4 * P * n + GAP;
                acc_cyc = cyc;
                accepted++;
            end
        end

        always @(negedge clk) begin
            logic [1:0] eab;
            logic       ebusy;
            logic       edone;
            int         ecnt;
            int         ph;
            eab   = 2'b00;
            ebusy = 1'b0;
            edone = 1'b0;
            ecnt  = cnt_hold;
            if (active) begin
                if (t < 4 * P * n) begin
                    ph    = (t % (4 * P)) / P;
                    eab   = (ph == 0) ? 2'b00 :
                            (ph == 1) ? (m_dir ? 2'b01 : 2'b10) :
                            (ph == 2) ? 2'b11 :
                                        (m_dir ? 2'b10 : 2'b01);
                    ebusy = 1'b1;
                    ecnt  = t / (4 * P);
                end else if (t < tt) begin
                    ebusy = 1'b1;
                    ecnt  = n;
                end else begin
                    edone = 1'b1;
                    ecnt  = n;
                end
            end
            chk("cycle_outputs", gi, outs(gi), int'({eab, ebusy, edone, AW'(ecnt)}));
            if (!forced) begin
                chk("gray_step", gi, int'(({a_o[gi], b_o[gi]} ^ prev_ab) == 2'b11), 0);
            end
            prev_ab = {a_o[gi], b_o[gi]};
            if (done_o[gi]) begin
                dones++;
                last_lat = cyc - acc_cyc + 1;
            end
        end
    end

    task automatic pulse_start(input logic d, input int na);
        dir   = d;
        axles = AW'(na);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy_o[0] && !done_o[0] && !busy_o[1] && !done_o[1]) begin
                idle = 1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_idle", 0, int'(idle), 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        dir   = 1'b0;
        axles = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", 0, outs(0), 0);
        chk("reset_state", 1, outs(1), 0);
        rst = 1'b0;
        @(negedge clk);

        // a->b, 16 axles
        pulse_start(1'b0, 16);
        wait_idle();
        chk("lat_a2b_16", 0, g_inst[0].last_lat, 69);
        chk("lat_a2b_16", 1, g_inst[1].last_lat, 133);
        chk("cnt_a2b_16", 0, int'(cnt_o[0]), 16);
        chk("cnt_a2b_16", 1, int'(cnt_o[1]), 16);

        // b->a, 3 axles
        pulse_start(1'b1, 3);
        wait_idle();
        chk("lat_b2a_3", 1, g_inst[1].last_lat, 29);
        chk("lat_b2a_3", 0, g_inst[0].last_lat, 17);

        // zero axles
        pulse_start(1'b0, 0);
        wait_idle();
        chk("lat_zero", 0, g_inst[0].last_lat, 1);
        chk("lat_zero", 1, g_inst[1].last_lat, 1);

        // abort in BOTH of axle 2 (instance 0), then restart
        pulse_start(1'b0, 5);
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_out", 0, outs(0), 1);
        chk("abort_out", 1, outs(1), 0);
        pulse_start(1'b0, 2);
        wait_idle();
        chk("lat_after_abort", 0, g_inst[0].last_lat, 13);
        chk("lat_after_abort", 1, g_inst[1].last_lat, 21);

        // start during busy and during DONE of instance 0
        pulse_start(1'b0, 2);
        repeat (3) @(negedge clk);
        pulse_start(1'b1, 7);
        repeat (8) @(negedge clk);
        pulse_start(1'b1, 7);
        wait_idle();
        chk("lat_ignored_start", 0, g_inst[0].last_lat, 13);
        chk("lat_ignored_start", 1, g_inst[1].last_lat, 21);
        chk("cnt_ignored_start", 0, int'(cnt_o[0]), 2);
        chk("cnt_ignored_start", 1, int'(cnt_o[1]), 2);

        // reset held 2 cycles mid-train
        pulse_start(1'b1, 4);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midtrain_reset", 0, outs(0), 0);
        chk("midtrain_reset", 1, outs(1), 0);
        rst = 1'b0;
        @(negedge clk);

        // randomized trains with stray starts and occasional aborts
        for (int it = 0; it < 40; it++) begin
            int  k;
            bit  do_abort;
            pulse_start(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
            k        = int'($urandom_range(1, 30));
            do_abort = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < k; c++) begin
                start = ($urandom_range(0, 5) == 0);
                dir   = 1'($urandom_range(0, 1));
                axles = AW'($urandom_range(0, 6));
                abort = do_abort && (c == k - 1);
                @(negedge clk);
            end
            start = 1'b0;
            abort = 1'b0;
            wait_idle();
        end

        chk("done_count", 0, g_inst[0].dones, g_inst[0].accepted - g_inst[0].killed);
        chk("done_count", 1, g_inst[1].dones, g_inst[1].accepted - g_inst[1].killed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
